// File: rtl/add_arbiter_pkg.sv
// Shared sizing constants for the adder arbiter: default width, requester count,
// tag width and result-FIFO entry width.
package add_arbiter_pkg;
   localparam int ADD_WIDTH = 64;
   localparam int ADD_NREQ  = 4;
   localparam int ADD_IDW   = $clog2(ADD_NREQ);

   // FIFO entry layout is {id, sum, cout}
   function automatic int entry_w(input int idw, input int width);
      return idw + width + 1;
   endfunction

   localparam int ADD_ENTRY_W = entry_w(ADD_IDW, ADD_WIDTH);
endpackage

// File: rtl/add_arb_fifo.sv
// Synchronous result FIFO with occupancy count; push and pop may coincide,
// including a push into a full FIFO that is being popped in the same cycle.
module add_arb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  dout_o,
   output logic [CW-1:0] count_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
         if (do_pop) rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
         case ({push_i, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // The issue-credit rule upstream must make this unreachable
   always_ff @(posedge clk_i) begin
      if (!rst_i && push_i && !do_pop) assert (cnt_q != FULL);
   end
endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one registered adder among NREQ requesters;
// results are tagged with the requester id and returned through a credit-protected FIFO.
module add_arbiter import add_arbiter_pkg::*; #(
   parameter int NREQ   = ADD_NREQ,
   parameter int WIDTH  = ADD_WIDTH,
   parameter int FDEPTH = 2,
   parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_cin,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   output logic                  add_cin,
   input  logic [WIDTH-1:0]      add_s,
   input  logic                  add_cout,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_s,
   output logic                  rsp_cout
);
   localparam int EW = entry_w(IDW, WIDTH);
   localparam int CW = $clog2(FDEPTH + 1);
   localparam logic [CW:0]    FDEPTH_C = (CW + 1)'(FDEPTH);
   localparam logic [IDW-1:0] LAST     = IDW'(NREQ - 1);

   logic [IDW-1:0] ptr_q, ptr_d, tag_id_q, win_id;
   logic           tag_v_q, grant, can_issue, pop;
   logic [CW-1:0]  fifo_count;
   logic [CW:0]    occ;
   logic [EW-1:0]  fifo_dout;

   // In-flight tag plus queued results must never exceed FIFO capacity,
   // except when a pop this cycle frees the slot the new issue will need.
   assign occ       = {{CW{1'b0}}, tag_v_q} + {1'b0, fifo_count};
   assign rsp_valid = (fifo_count != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign can_issue = (occ < FDEPTH_C) || ((occ == FDEPTH_C) && pop);

   always_comb begin
      grant  = 1'b0;
      win_id = '0;
      for (int k = 0; k < NREQ; k++) begin : g_search
         int idx;
         idx = (int'(ptr_q) + k) % NREQ;
         if (!grant && req_valid[idx]) begin
            grant  = 1'b1;
            win_id = idx[IDW-1:0];
         end
      end
      if (rst || !can_issue) begin
         grant  = 1'b0;
         win_id = '0;
      end
   end

   always_comb begin
      req_ready = '0;
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
      if (grant) begin
         req_ready[win_id] = 1'b1;
         add_a   = req_a[int'(win_id)*WIDTH +: WIDTH];
         add_b   = req_b[int'(win_id)*WIDTH +: WIDTH];
         add_cin = req_cin[win_id];
      end
   end

   assign ptr_d = grant ? ((win_id == LAST) ? '0 : win_id + 1'b1) : ptr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q    <= '0;
         tag_v_q  <= 1'b0;
         tag_id_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         tag_v_q  <= grant;
         tag_id_q <= win_id;
      end
   end

   add_arb_fifo #(.DEPTH(FDEPTH), .W(EW), .CW(CW)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (tag_v_q),
      .pop_i   (pop),
      .din_i   ({tag_id_q, add_s, add_cout}),
      .dout_o  (fifo_dout),
      .count_o (fifo_count)
   );

   assign {rsp_id, rsp_s, rsp_cout} = rsp_valid ? fifo_dout : '0;
endmodule
